// File: rtl/map_store.sv
// map_store: dual-buffered wall map with a serial edit port.
// The tracer reads the active plane combinationally; serial frames edit a
// shadow plane, which is copied to the active plane on each vsync rising edge.
// Optional feature macro: MAP_BORDER_EN (force the map border to read as wall).
module map_store #(
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vsync,
    input  logic [MAP_WIDTH_BITS-1:0]  i_map_col,
    input  logic [MAP_HEIGHT_BITS-1:0] i_map_row,
    output logic                       o_map_val,
    input  logic                       spi_sclk,
    input  logic                       spi_mosi,
    input  logic                       spi_csb,
    output logic                       o_pending
);
    localparam int IDX_BITS   = MAP_WIDTH_BITS + MAP_HEIGHT_BITS;
    localparam int CELLS      = 1 << IDX_BITS;
    localparam int FRAME_BITS = 2 + IDX_BITS;
    localparam int CNT_BITS   = $clog2(FRAME_BITS + 1);

    logic [2:0]            sclk_s;
    logic [1:0]            mosi_s;
    logic [1:0]            csb_s;
    logic                  sclk_rise;
    logic [CNT_BITS-1:0]   bit_cnt;
    logic [FRAME_BITS-2:0] shift_q;
    logic [FRAME_BITS-1:0] frame_word;
    logic                  edit_fire;
    logic                  edit_op;
    logic                  edit_val;
    logic [IDX_BITS-1:0]   edit_idx;
    logic [CELLS-1:0]      active;
    logic [CELLS-1:0]      shadow;
    logic [CELLS-1:0]      shadow_next;
    logic                  vsync_q;
    logic                  commit;
    logic                  raw_val;

    // Bring the serial pins into the clk domain; sclk gets a third stage for edge detect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_s <= 3'b000;
            mosi_s <= 2'b00;
            csb_s  <= 2'b11;
        end else begin
            sclk_s <= {sclk_s[1:0], spi_sclk};
            mosi_s <= {mosi_s[0], spi_mosi};
            csb_s  <= {csb_s[0], spi_csb};
        end
    end

    assign sclk_rise  = sclk_s[1] & ~sclk_s[2];
    assign frame_word = {shift_q, mosi_s[1]};
    assign edit_fire  = sclk_rise & ~csb_s[1] & (bit_cnt == CNT_BITS'(FRAME_BITS - 1));
    assign edit_op    = frame_word[FRAME_BITS-1];
    assign edit_val   = frame_word[FRAME_BITS-2];
    assign edit_idx   = frame_word[IDX_BITS-1:0];

    // Shift in frame bits MSB first; the counter saturates at a full frame so
    // extra bits are ignored, and clears while chip select is idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (csb_s[1]) begin
            bit_cnt <= '0;
        end else if (sclk_rise && (bit_cnt != CNT_BITS'(FRAME_BITS))) begin
            shift_q <= frame_word[FRAME_BITS-2:0];
            bit_cnt <= bit_cnt + CNT_BITS'(1);
        end
    end

    // Shadow including this cycle's edit, so a commit in the same cycle carries it.
    always_comb begin
        shadow_next = shadow;
        if (edit_fire) begin
            if (edit_op) begin
                shadow_next = {CELLS{edit_val}};
            end else begin
                shadow_next[edit_idx] = edit_val;
            end
        end
    end

    assign commit = vsync & ~vsync_q;

    // Plane storage, vsync edge detect and the pending flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active    <= '0;
            shadow    <= '0;
            vsync_q   <= 1'b0;
            o_pending <= 1'b0;
        end else begin
            shadow  <= shadow_next;
            vsync_q <= vsync;
            if (commit) begin
                active    <= shadow_next;
                o_pending <= 1'b0;
            end else if (edit_fire) begin
                o_pending <= 1'b1;
            end
        end
    end

    assign raw_val = active[{i_map_row, i_map_col}];

`ifdef MAP_BORDER_EN
    // Border cells always read as wall so every ray terminates.
    always_comb begin
        o_map_val = raw_val;
        if ((i_map_col == '0) || (i_map_col == '1) ||
            (i_map_row == '0) || (i_map_row == '1)) begin
            o_map_val = 1'b1;
        end
    end
`else
    assign o_map_val = raw_val;
`endif

endmodule
